// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. The result is computed when the
// request is accepted and held in pending registers until the latency counter expires.
//
// state  | meaning
// S_IDLE | no operation in flight, requests are accepted
// S_RUN  | multi-cycle op in flight, counter runs down to commit
module mul_div_unit #(
  parameter int MUL_LATENCY = 5,
  parameter int DIV_LATENCY = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ctrl,
  input  logic        enable,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        outputSel,
  output logic [31:0] out,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CW = $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [31:0]   pend_hi, pend_lo;
  logic          accept, commit, is_valid, is_mt, is_div;
  logic [CW-1:0] lat_sel;
  logic [63:0]   prod_s, prod_u, acc, res;
  logic [31:0]   quot_s, rem_s;

  assign is_valid = enable && (ctrl >= OP_MULT) && (ctrl <= OP_MSUB);
  assign is_mt    = (ctrl == OP_MTHI) || (ctrl == OP_MTLO);
  assign is_div   = (ctrl == OP_DIV) || (ctrl == OP_DIVU);
  assign lat_sel  = is_div ? CW'(DIV_LATENCY) : CW'(MUL_LATENCY);
  assign busy     = (state == S_RUN);
  assign out      = outputSel ? hi : lo;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_valid) begin
          accept = 1'b1;
          if (!is_mt) state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (count == CW'(1)) begin
          commit    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Full-width operands so the 64-bit products need no extra truncation.
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign quot_s = $signed(a) / $signed(b);
  assign rem_s  = $signed(a) % $signed(b);
  assign acc    = {hi, lo};

  always_comb begin
    res = acc;
    case (ctrl)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_MADD:  res = acc + prod_s;
      OP_MADDU: res = acc + prod_u;
      OP_MSUB:  res = acc - prod_s;
      OP_DIV: begin
        if (b == 32'd0)
          res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          res = {32'd0, 32'h8000_0000};
        else
          res = {rem_s, quot_s};
      end
      OP_DIVU: begin
        if (b == 32'd0)
          res = {a, 32'hFFFF_FFFF};
        else
          res = {a % b, a / b};
      end
      default: res = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      count   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (ctrl == OP_MTHI) begin
          hi <= a;
        end else if (ctrl == OP_MTLO) begin
          lo <= a;
        end else begin
          pend_hi <= res[63:32];
          pend_lo <= res[31:0];
          count   <= lat_sel;
        end
      end else if (state == S_RUN) begin
        count <= count - CW'(1);
      end
      if (commit) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus queues expected HI/LO, a monitor
// compares whenever a result lands (busy falling, or an mthi/mtlo accepted).
module tb_mul_div_unit;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  ctrl = 4'd0;
  logic        enable = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        outputSel = 1'b0;
  logic [31:0] out, hi, lo;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    string       nm;
  } exp_t;

  exp_t sb[$];

  mul_div_unit #(.MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .ctrl(ctrl), .enable(enable), .a(a), .b(b),
    .outputSel(outputSel), .out(out), .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Bus monitor: notes accepted mthi/mtlo and whether reset was applied.
  logic mt_acc = 1'b0;
  logic rst_low = 1'b1;
  logic prev_busy = 1'b0;

  always @(posedge clk) begin
    mt_acc  <= reset && enable && (busy === 1'b0) && (ctrl == 4'd5 || ctrl == 4'd6);
    rst_low <= !reset;
  end

  always @(negedge clk) begin
    if (!rst_low && (mt_acc || (prev_busy === 1'b1 && busy === 1'b0))) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: hi %08h lo %08h with nothing expected", hi, lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_hi"}, hi, e.h);
        chk({e.nm, "_lo"}, lo, e.l);
        chk({e.nm, "_out"}, out, outputSel ? e.h : e.l);
      end
    end
    prev_busy = busy;
  end

  // Drive one request for a single cycle; returns at the negedge after acceptance
  // with operands scrambled so late operand changes would be caught.
  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eh, input logic [31:0] el, input bit push,
                       input string nm);
    exp_t e;
    if (push) begin
      e.h = eh; e.l = el; e.nm = nm;
      sb.push_back(e);
    end
    ctrl = op; a = av; b = bv; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0; ctrl = 4'd0;
    a = 32'hDEAD_BEEF; b = 32'h1357_9BDF;
  endtask

  task automatic expect_busy(input int lat, input string nm);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, 32'(n), 32'(lat));
  endtask

  task automatic op(input logic [3:0] opc, input logic [31:0] av, input logic [31:0] bv,
                    input logic [31:0] eh, input logic [31:0] el, input int lat,
                    input string nm);
    issue(opc, av, bv, eh, el, 1'b1, nm);
    if (lat == 0) chk({nm, "_nobusy"}, {31'd0, busy}, 32'd0);
    else expect_busy(lat, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_out", out, 32'd0);

    // Back-to-back moves, no busy.
    op(4'd5, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'd0, 0, "mthi");
    op(4'd6, 32'h0000_0001, 32'd0, 32'h1234_5678, 32'd1, 0, "mtlo");

    op(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, "div_m7_2");

    // Reset three cycles into a divide: nothing may ever commit.
    issue(4'd3, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, "div_abort");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (15) @(negedge clk);
    chk("abort_late_busy", {31'd0, busy}, 32'd0);
    chk("abort_late_hi", hi, 32'd0);
    chk("abort_late_lo", lo, 32'd0);

    op(4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT, "mult");
    op(4'd2, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MUL_LAT, "multu");
    op(4'd4, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, DIV_LAT, "divu_by0");
    op(4'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_LAT, "div_7_m2");
    op(4'd3, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_LAT, "div_by0");

    // Disabled and out-of-range requests change nothing.
    ctrl = 4'd1; a = 32'd9; b = 32'd9; enable = 1'b0;
    @(negedge clk);
    ctrl = 4'd12; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0; ctrl = 4'd0;
    chk("disabled_busy", {31'd0, busy}, 32'd0);
    chk("disabled_hi", hi, 32'hFFFF_FFFB);

    op(4'd6, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, "mtlo_chain");
    op(4'd5, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, "mthi_chain");
    op(4'd7, 32'd1, 32'd1, 32'd1, 32'd0, MUL_LAT, "madd");
    op(4'd9, 32'd2, 32'd1, 32'd0, 32'hFFFF_FFFE, MUL_LAT, "msub");
    op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT, "div_ovf");
    op(4'd8, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'h7FFF_FFFE, MUL_LAT, "maddu");

    // Request while busy is ignored; reads show the old HI/LO until commit.
    issue(4'd3, 32'd20, 32'd3, 32'd2, 32'd6, 1'b1, "div_hold");
    chk("hold_busy_t1", {31'd0, busy}, 32'd1);
    ctrl = 4'd1; a = 32'd9; b = 32'd9; enable = 1'b1;
    outputSel = 1'b1;
    #1 chk("hold_out_hi", out, 32'd2);
    @(negedge clk);
    chk("hold_busy_t2", {31'd0, busy}, 32'd1);
    outputSel = 1'b0;
    #1 chk("hold_out_lo", out, 32'h7FFF_FFFE);
    enable = 1'b0; ctrl = 4'd0;
    @(negedge clk);
    expect_busy(DIV_LAT - 2, "div_hold");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
